// File: rtl/interrupt_pkg.sv
// Shared constants, FSM state encoding and arbitration result type for the interrupt controller.
package interrupt_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned LVL_W   = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_ACK = 2'd2,
    SERVICE  = 2'd3
  } intState_t;

  // Identity of one interrupt source together with its programmed level
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LVL_W-1:0] lvl;
  } winner_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Synchronises one asynchronous request line and emits a registered one-cycle rising-edge pulse.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic Reset,
  input  logic irqIn,
  output logic risePulse
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   prevQ;

  // Synchroniser chain, previous-value flop and registered edge pulse
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      syncQ     <= '0;
      prevQ     <= 1'b0;
      risePulse <= 1'b0;
    end else begin
      syncQ     <= {syncQ[SYNC_STAGES-2:0], irqIn};
      prevQ     <= syncQ[SYNC_STAGES-1];
      risePulse <= syncQ[SYNC_STAGES-1] & ~prevQ;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Four-source interrupt controller: captures requests, arbitrates by level and
// presents one interrupt at a time to the datapath with an ack/done handshake.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [NUM_SRC-1:0]        irq_in,
  input  logic [NUM_SRC*DATA_W-1:0] irq_data,
  input  logic                      mask_we,
  input  logic [NUM_SRC-1:0]        mask_in,
  input  logic                      lvl_we,
  input  logic [NUM_SRC*LVL_W-1:0]  lvl_in,
  input  logic                      int_ack,
  input  logic                      int_done,
  output logic                      intWrite,
  output logic [DATA_W-1:0]         intDataIn,
  output logic                      int0,
  output logic                      int1,
  output logic                      intLvl0,
  output logic                      intLvl1,
  output logic [NUM_SRC-1:0]        pending,
  output logic [NUM_SRC-1:0]        overrun,
  output logic                      busy
);

  intState_t                 state;
  intState_t                 nextState;
  logic [NUM_SRC-1:0]        rise;
  logic [NUM_SRC-1:0]        maskQ;
  logic [NUM_SRC*LVL_W-1:0]  lvlQ;
  logic [DATA_W-1:0]         payloadQ [NUM_SRC];
  logic [NUM_SRC-1:0]        eligible;
  logic [NUM_SRC-1:0]        ackClr;
  logic                      arbValid;
  winner_t                   arbWin;
  winner_t                   curWin;
  logic [DATA_W-1:0]         curData;

  for (genvar g = 0; g < NUM_SRC; g++) begin : gSync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSync (
      .CLK      (CLK),
      .Reset    (Reset),
      .irqIn    (irq_in[g]),
      .risePulse(rise[g])
    );
  end

  // Software-programmed enable mask and per-source levels
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      maskQ <= '0;
      lvlQ  <= '0;
    end else begin
      if (mask_we) maskQ <= mask_in;
      if (lvl_we)  lvlQ  <= lvl_in;
    end
  end

  // Acknowledge of the presented source clears its pending bit
  always_comb begin
    ackClr = '0;
    if (state == WAIT_ACK && int_ack) ackClr = NUM_SRC'(1) << curWin.id;
  end

  // Pending/overrun/payload capture; a new edge wins over a same-cycle acknowledge
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pending <= '0;
      overrun <= '0;
      for (int i = 0; i < NUM_SRC; i++) payloadQ[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (rise[i]) begin
          pending[i] <= 1'b1;
          if (pending[i] && !ackClr[i]) overrun[i] <= 1'b1;
          else payloadQ[i] <= irq_data[i*DATA_W +: DATA_W];
        end else if (ackClr[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Priority arbiter: highest level wins, ties go to the lowest index
  always_comb begin
    eligible = pending & maskQ;
    arbValid = 1'b0;
    arbWin   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (!arbValid || lvlQ[i*LVL_W +: LVL_W] > arbWin.lvl)) begin
        arbValid   = 1'b1;
        arbWin.id  = ID_W'(i);
        arbWin.lvl = lvlQ[i*LVL_W +: LVL_W];
      end
    end
  end

  // Handshake state register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // Handshake next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (arbValid) nextState = PRESENT;
      PRESENT:  nextState = WAIT_ACK;
      WAIT_ACK: if (int_ack)  nextState = SERVICE;
      SERVICE:  if (int_done) nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Winner is frozen when leaving IDLE so later mask/level changes cannot disturb it
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      curWin  <= '0;
      curData <= '0;
    end else if (state == IDLE && arbValid) begin
      curWin  <= arbWin;
      curData <= payloadQ[arbWin.id];
    end
  end

  // Registered datapath-facing outputs
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      intWrite           <= 1'b0;
      intDataIn          <= '0;
      {int1, int0}       <= '0;
      {intLvl1, intLvl0} <= '0;
      busy               <= 1'b0;
    end else begin
      intWrite <= (state == PRESENT);
      busy     <= (nextState != IDLE);
      if (state == PRESENT) begin
        intDataIn          <= curData;
        {int1, int0}       <= curWin.id;
        {intLvl1, intLvl0} <= curWin.lvl;
      end else if (state == SERVICE && int_done) begin
        intDataIn          <= '0;
        {int1, int0}       <= '0;
        {intLvl1, intLvl0} <= '0;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller with a level-ordered service model.
module tb_interrupt_controller;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NSRC   = 4;

  logic                   CLK = 1'b0;
  logic                   Reset;
  logic [NSRC-1:0]        irq_in;
  logic [NSRC*DATA_W-1:0] irq_data;
  logic                   mask_we;
  logic [NSRC-1:0]        mask_in;
  logic                   lvl_we;
  logic [NSRC*2-1:0]      lvl_in;
  logic                   int_ack;
  logic                   int_done;
  logic                   intWrite;
  logic [DATA_W-1:0]      intDataIn;
  logic                   int0, int1, intLvl0, intLvl1;
  logic [NSRC-1:0]        pending;
  logic [NSRC-1:0]        overrun;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  interrupt_controller #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .Reset(Reset), .irq_in(irq_in), .irq_data(irq_data),
    .mask_we(mask_we), .mask_in(mask_in), .lvl_we(lvl_we), .lvl_in(lvl_in),
    .int_ack(int_ack), .int_done(int_done), .intWrite(intWrite),
    .intDataIn(intDataIn), .int0(int0), .int1(int1), .intLvl0(intLvl0),
    .intLvl1(intLvl1), .pending(pending), .overrun(overrun), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic setMask(input logic [NSRC-1:0] m);
    mask_in = m; mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic setLevels(input logic [NSRC*2-1:0] l);
    lvl_in = l; lvl_we = 1'b1;
    tick();
    lvl_we = 1'b0;
  endtask

  task automatic doReset();
    #2 Reset = 1'b0;
    #3 Reset = 1'b1;
  endtask

  task automatic setPayload(input int src, input logic [DATA_W-1:0] d);
    irq_data[src*DATA_W +: DATA_W] = d;
  endtask

  task automatic pulseIrq(input logic [NSRC-1:0] srcs);
    irq_in = srcs;
    tick(); tick();
    irq_in = '0;
  endtask

  // Wait a bounded number of cycles for the intWrite strobe and capture what it presents
  task automatic waitIntWrite(input int budget, output bit found, output logic [1:0] id,
                              output logic [1:0] lv, output logic [DATA_W-1:0] data);
    found = 1'b0; id = '0; lv = '0; data = '0;
    for (int n = 0; n < budget && !found; n++) begin
      tick();
      if (intWrite === 1'b1) begin
        found = 1'b1; id = {int1, int0}; lv = {intLvl1, intLvl0}; data = intDataIn;
      end
    end
  endtask

  task automatic handshake();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #7;
    checks++; if ({intWrite, intDataIn, int1, int0, intLvl1, intLvl0} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", {intWrite, intDataIn, int1, int0, intLvl1, intLvl0}); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b want 0000", pending); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL reset_overrun: got %b want 0000", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    setMask(4'hF);
    setPayload(2, 16'hBEEF);
    irq_in[2] = 1'b1;
    tick(); tick(); tick();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL basic_early_pending: got %b want 0000", pending); end
    tick();
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL basic_pending: got %b want 0100", pending); end
    irq_in[2] = 1'b0;
    tick();
    checks++; if ({intWrite, busy} !== 2'b01) begin errors++; $display("FAIL basic_present: got write/busy %b want 01", {intWrite, busy}); end
    tick();
    checks++; if (intWrite !== 1'b1) begin errors++; $display("FAIL basic_strobe: got %b want 1", intWrite); end
    checks++; if ({int1, int0, intLvl1, intLvl0, intDataIn} !== {2'b10, 2'b00, 16'hBEEF}) begin
      errors++; $display("FAIL basic_payload: got id %b lvl %b data %h want 10 00 beef", {int1, int0}, {intLvl1, intLvl0}, intDataIn); end
    tick();
    checks++; if ({intWrite, int1, int0, intDataIn} !== {1'b0, 2'b10, 16'hBEEF}) begin
      errors++; $display("FAIL basic_hold: got write %b id %b data %h", intWrite, {int1, int0}, intDataIn); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++; if ({pending, busy, intDataIn} !== {4'b0000, 1'b1, 16'hBEEF}) begin
      errors++; $display("FAIL basic_ack: got pending %b busy %b data %h", pending, busy, intDataIn); end
    int_done = 1'b1; tick(); int_done = 1'b0;
    checks++; if ({busy, intWrite, intDataIn, int1, int0, intLvl1, intLvl0} !== '0) begin
      errors++; $display("FAIL basic_done: got busy %b data %h id %b", busy, intDataIn, {int1, int0}); end
  endtask

  task automatic test_priority();
    int expId [4] = '{1, 2, 3, 0};
    logic [1:0] expLv [4] = '{2'd3, 2'd3, 2'd1, 2'd0};
    logic [DATA_W-1:0] d [4];
    bit found; logic [1:0] id, lv; logic [DATA_W-1:0] data;
    setLevels({2'd1, 2'd3, 2'd3, 2'd0});
    for (int i = 0; i < 4; i++) begin d[i] = DATA_W'($urandom); setPayload(i, d[i]); end
    pulseIrq(4'hF);
    for (int k = 0; k < 4; k++) begin
      waitIntWrite(8, found, id, lv, data);
      checks++; if (!found || id !== 2'(expId[k]) || lv !== expLv[k] || data !== d[expId[k]]) begin
        errors++; $display("FAIL prio_order%0d: got found %0b id %0d lvl %0d data %h want id %0d lvl %0d data %h",
                           k, found, id, lv, data, expId[k], expLv[k], d[expId[k]]); end
      handshake();
    end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL prio_drain: got %b want 0000", pending); end
  endtask

  task automatic test_mask();
    bit found; bit sawWrite; logic [1:0] id, lv; logic [DATA_W-1:0] data, d0;
    setLevels('0);
    setMask(4'h0);
    d0 = DATA_W'($urandom);
    setPayload(0, d0);
    pulseIrq(4'b0001);
    sawWrite = 1'b0;
    repeat (8) begin tick(); if (intWrite !== 1'b0) sawWrite = 1'b1; end
    checks++; if ({pending, sawWrite, busy} !== {4'b0001, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mask_block: got pending %b write %b busy %b want 0001 0 0", pending, sawWrite, busy); end
    setMask(4'h1);
    waitIntWrite(2, found, id, lv, data);
    checks++; if (!found || id !== 2'd0 || data !== d0) begin
      errors++; $display("FAIL mask_enable: got found %0b id %0d data %h want 1 0 %h", found, id, data, d0); end
    handshake();
    setMask(4'hF);
  endtask

  task automatic test_overrun();
    bit found; logic [1:0] id, lv; logic [DATA_W-1:0] data, dA, dB;
    setMask(4'b1101);
    dA = DATA_W'($urandom);
    dB = ~dA;
    setPayload(1, dA);
    pulseIrq(4'b0010);
    repeat (3) tick();
    checks++; if ({pending, overrun} !== {4'b0010, 4'b0000}) begin
      errors++; $display("FAIL ovr_first: got pending %b overrun %b want 0010 0000", pending, overrun); end
    setPayload(1, dB);
    pulseIrq(4'b0010);
    repeat (3) tick();
    checks++; if ({pending, overrun, busy} !== {4'b0010, 4'b0010, 1'b0}) begin
      errors++; $display("FAIL ovr_second: got pending %b overrun %b busy %b want 0010 0010 0", pending, overrun, busy); end
    setMask(4'hF);
    waitIntWrite(4, found, id, lv, data);
    checks++; if (!found || id !== 2'd1 || data !== dA) begin
      errors++; $display("FAIL ovr_payload_kept: got found %0b id %0d data %h want 1 1 %h", found, id, data, dA); end
    handshake();
    checks++; if ({pending, overrun} !== {4'b0000, 4'b0010}) begin
      errors++; $display("FAIL ovr_sticky: got pending %b overrun %b want 0000 0010", pending, overrun); end
  endtask

  task automatic test_ack_collision();
    bit found; logic [1:0] id, lv; logic [DATA_W-1:0] data, dA, dC;
    doReset();
    setMask(4'hF);
    dA = DATA_W'($urandom);
    dC = dA ^ 16'h5AA5;
    setPayload(1, dA);
    pulseIrq(4'b0010);
    waitIntWrite(8, found, id, lv, data);
    checks++; if (!found || id !== 2'd1 || data !== dA) begin
      errors++; $display("FAIL coll_first: got found %0b id %0d data %h want 1 1 %h", found, id, data, dA); end
    setPayload(1, dC);
    irq_in[1] = 1'b1;
    tick(); tick(); tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    irq_in[1] = 1'b0;
    checks++; if ({pending, overrun, busy} !== {4'b0010, 4'b0000, 1'b1}) begin
      errors++; $display("FAIL coll_setwins: got pending %b overrun %b busy %b want 0010 0000 1", pending, overrun, busy); end
    int_done = 1'b1; tick(); int_done = 1'b0;
    waitIntWrite(6, found, id, lv, data);
    checks++; if (!found || id !== 2'd1 || data !== dC) begin
      errors++; $display("FAIL coll_represent: got found %0b id %0d data %h want 1 1 %h", found, id, data, dC); end
    handshake();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL coll_drain: got %b want 0000", pending); end
  endtask

  task automatic test_reset_midflight();
    bit found; logic [1:0] id, lv; logic [DATA_W-1:0] data;
    setPayload(3, DATA_W'($urandom));
    pulseIrq(4'b1000);
    waitIntWrite(8, found, id, lv, data);
    tick();
    checks++; if (!found || busy !== 1'b1) begin errors++; $display("FAIL rst_setup: got found %0b busy %b want 1 1", found, busy); end
    #2 Reset = 1'b0;
    #1;
    checks++; if ({busy, pending, overrun, intWrite, intDataIn, int1, int0, intLvl1, intLvl0} !== '0) begin
      errors++; $display("FAIL rst_immediate: got busy %b pending %b data %h id %b", busy, pending, intDataIn, {int1, int0}); end
    #2 Reset = 1'b1;
    tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    int_done = 1'b1; tick(); int_done = 1'b0;
    tick();
    checks++; if ({busy, intWrite} !== 2'b00) begin errors++; $display("FAIL rst_idle_ignore: got busy/write %b want 00", {busy, intWrite}); end
    pulseIrq(4'b0001);
    repeat (6) tick();
    checks++; if ({pending, busy} !== {4'b0001, 1'b0}) begin
      errors++; $display("FAIL rst_mask_cleared: got pending %b busy %b want 0001 0", pending, busy); end
    doReset();
  endtask

  task automatic test_random_priority();
    bit found; logic [1:0] id, lv; logic [DATA_W-1:0] data;
    logic [1:0] lvs [4];
    logic [DATA_W-1:0] d [4];
    logic [NSRC-1:0] req;
    int order [$];
    bit stop;
    setMask(4'hF);
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 4; i++) begin
        lvs[i] = 2'($urandom_range(0, 3));
        d[i] = DATA_W'($urandom);
        setPayload(i, d[i]);
      end
      setLevels({lvs[3], lvs[2], lvs[1], lvs[0]});
      req = 4'($urandom_range(1, 15));
      // Service order: by level descending, then by source index ascending
      order = {};
      for (int l = 3; l >= 0; l--)
        for (int i = 0; i < 4; i++)
          if (req[i] && int'(lvs[i]) == l) order.push_back(i);
      pulseIrq(req);
      stop = 1'b0;
      foreach (order[k]) begin
        if (!stop) begin
          waitIntWrite(10, found, id, lv, data);
          checks++; if (!found || id !== 2'(order[k]) || lv !== lvs[order[k]] || data !== d[order[k]]) begin
            errors++; stop = !found;
            $display("FAIL rand%0d_svc%0d: got found %0b id %0d lvl %0d data %h want id %0d lvl %0d data %h",
                     it, k, found, id, lv, data, order[k], lvs[order[k]], d[order[k]]);
          end
          repeat ($urandom_range(0, 2)) tick();
          handshake();
        end
      end
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rand%0d_drain: got %b want 0000", it, pending); end
    end
  endtask

  initial begin
    irq_in = '0; irq_data = '0; mask_we = 1'b0; mask_in = '0;
    lvl_we = 1'b0; lvl_in = '0; int_ack = 1'b0; int_done = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_overrun();
    test_ack_collision();
    test_reset_midflight();
    test_random_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
